// File: rtl/modinv_euclid_if.sv
// Request/response bundle of the modular-inverse unit: operands and start in,
// status and results out.
`timescale 1ns/1ps
interface modinv_euclid_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] m;
  logic         neg;
  logic         busy;
  logic         done;
  logic [W-1:0] inv;
  logic [W-1:0] gcd;
  logic         no_inv;

  modport master (output start, a, m, neg, input busy, done, inv, gcd, no_inv);
  modport slave  (input start, a, m, neg, output busy, done, inv, gcd, no_inv);
endinterface

// File: rtl/modinv_euclid.sv
// Sequential modular inverse by extended Euclid: one restoring division step per
// cycle, with the quotient*t1 product accumulated Horner-style alongside it.
`timescale 1ns/1ps
module modinv_euclid #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  modinv_euclid_if.slave bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, UPD, FIN} state_t;

  state_t              state_q;
  logic [W-1:0]        m_q;
  logic                neg_q;
  logic [W-1:0]        r0_q;
  logic [W-1:0]        r1_q;
  logic [W-1:0]        rem_q;
  logic signed [W+1:0] t0_q;
  logic signed [W+1:0] t1_q;
  logic signed [W+1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [W-1:0]        inv_q;
  logic [W-1:0]        gcd_q;
  logic                no_inv_q;

  logic [W:0]          trial_d;
  logic                qbit_d;
  logic [W-1:0]        rem_d;
  logic signed [W+1:0] acc_d;
  logic [W-1:0]        x_d;
  logic [W-1:0]        inv_d;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    trial_d = {rem_q, r0_q[cnt_q]};
    qbit_d  = (trial_d >= {1'b0, r1_q});
    rem_d   = W'(qbit_d ? (trial_d - {1'b0, r1_q}) : trial_d);
    acc_d   = (acc_q <<< 1) + (qbit_d ? t1_q : {(W+2){1'b0}});
  end

  // Final coefficient t0 lies in (-m, m); fold into [0, m) then optionally negate.
  always_comb begin
    x_d   = W'(t0_q[W+1] ? (t0_q + $signed({2'b00, m_q})) : t0_q);
    inv_d = (neg_q && (x_d != '0)) ? (m_q - x_d) : x_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      neg_q    <= 1'b0;
      r0_q     <= '0;
      r1_q     <= '0;
      rem_q    <= '0;
      t0_q     <= '0;
      t1_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      inv_q    <= '0;
      gcd_q    <= '0;
      no_inv_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The done cycle is spent in IDLE, so a start landing there is dropped.
          if (bus.start && !done_q) begin
            m_q     <= bus.m;
            neg_q   <= bus.neg;
            r0_q    <= bus.m;
            r1_q    <= bus.a;
            t0_q    <= '0;
            t1_q    <= (W+2)'(1);
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (r1_q == '0) begin
            state_q <= FIN;
          end else begin
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= CW'(W - 1);
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= UPD;
          end
        end
        UPD: begin
          r0_q    <= r1_q;
          r1_q    <= rem_q;
          t0_q    <= t1_q;
          t1_q    <= t0_q - acc_q;
          state_q <= CHECK;
        end
        FIN: begin
          gcd_q <= r0_q;
          if ((m_q < W'(2)) || (r0_q != W'(1))) begin
            no_inv_q <= 1'b1;
            inv_q    <= '0;
          end else begin
            no_inv_q <= 1'b0;
            inv_q    <= inv_d;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.inv    = inv_q;
  assign bus.gcd    = gcd_q;
  assign bus.no_inv = no_inv_q;

endmodule

// File: tb/tb_modinv_euclid.sv
// Bench for modinv_euclid: directed vector table, abort/ignore-start sequences and a
// random W=16 sweep against an arithmetic reference model; one W=32 wide-operand case.
`timescale 1ns/1ps
module tb_modinv_euclid;

  localparam int LIMIT = 5000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] m;
    bit          neg;
    logic [15:0] inv;
    logic [15:0] gcd;
    bit          noInv;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  modinv_euclid_if #(.W(16)) bus16 ();
  modinv_euclid_if #(.W(32)) bus32 ();

  modinv_euclid #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  modinv_euclid #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Textbook extended Euclid on plain integers; k counts division steps.
  function automatic void refModel(input longint a, input longint m, input bit neg,
                                   output longint inv, output longint gcd,
                                   output bit noInv, output int k);
    longint r0, r1, tmp, s0, s1, st, q, x;
    r0 = m; r1 = a; s0 = 0; s1 = 1; k = 0;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 % r1;
      r0  = r1;
      r1  = tmp;
      st  = s0 - q * s1;
      s0  = s1;
      s1  = st;
      k++;
    end
    gcd   = r0;
    noInv = (m < 2) || (r0 != 1);
    if (noInv) inv = 0;
    else begin
      x = s0 % m;
      if (x < 0) x += m;
      inv = (neg && x != 0) ? m - x : x;
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] m, input bit neg,
                               input int injectAt, output int lat, output bit timedOut,
                               output bit busyEarly);
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = a; bus16.m = m; bus16.neg = neg;
    @(negedge clk);
    bus16.start = 1'b0;
    lat = 1;
    busyEarly = bus16.busy;
    while (!bus16.done && lat < LIMIT) begin
      if (lat == injectAt) begin
        bus16.start = 1'b1; bus16.a = 16'd7; bus16.m = 16'd9; bus16.neg = 1'b1;
      end
      @(negedge clk);
      bus16.start = 1'b0;
      lat++;
    end
    timedOut = !bus16.done;
  endtask

  task automatic runAndCheck(input string tag, input logic [15:0] a, input logic [15:0] m,
                             input bit neg, input logic [15:0] expInv, input logic [15:0] expGcd,
                             input bit expNoInv, input int injectAt);
    longint mInv, mGcd;
    bit mNo, timedOut, busyEarly;
    int k, lat;
    refModel(longint'(a), longint'(m), neg, mInv, mGcd, mNo, k);
    applyStimulus(a, m, neg, injectAt, lat, timedOut, busyEarly);
    checkOutput({tag, " timeout"}, 64'(timedOut), 64'd0);
    checkOutput({tag, " busy"}, 64'(busyEarly), 64'd1);
    checkOutput({tag, " inv"}, 64'(bus16.inv), 64'(expInv));
    checkOutput({tag, " gcd"}, 64'(bus16.gcd), 64'(expGcd));
    checkOutput({tag, " no_inv"}, 64'(bus16.no_inv), 64'(expNoInv));
    checkOutput({tag, " latency"}, 64'(lat), 64'(3 + k * 18));
    checkOutput({tag, " busy_in_done"}, 64'(bus16.busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, 64'(bus16.done), 64'd0);
  endtask

  initial begin
    vec_t vecs[10];
    longint mInv, mGcd, prod;
    bit mNo, timedOut, busyEarly, sawDone;
    int k, lat;
    logic [15:0] ra, rm;
    bit rn;

    checks = 0; passed = 0;
    bus16.start = 1'b0; bus16.a = '0; bus16.m = '0; bus16.neg = 1'b0;
    bus32.start = 1'b0; bus32.a = '0; bus32.m = '0; bus32.neg = 1'b0;

    vecs[0] = '{16'd3,     16'd11,    1'b0, 16'd4,     16'd1, 1'b0};
    vecs[1] = '{16'd3,     16'd11,    1'b1, 16'd7,     16'd1, 1'b0};
    vecs[2] = '{16'd6,     16'd9,     1'b0, 16'd0,     16'd3, 1'b1};
    vecs[3] = '{16'd0,     16'd9,     1'b0, 16'd0,     16'd9, 1'b1};
    vecs[4] = '{16'd5,     16'd1,     1'b0, 16'd0,     16'd1, 1'b1};
    vecs[5] = '{16'd5,     16'd0,     1'b0, 16'd0,     16'd5, 1'b1};
    vecs[6] = '{16'd14,    16'd11,    1'b0, 16'd4,     16'd1, 1'b0};
    vecs[7] = '{16'd1,     16'd2,     1'b1, 16'd1,     16'd1, 1'b0};
    vecs[8] = '{16'hFFFF,  16'hFFFE,  1'b1, 16'hFFFD,  16'd1, 1'b0};
    vecs[9] = '{16'd7,     16'd7,     1'b0, 16'd0,     16'd7, 1'b1};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset busy", 64'(bus16.busy), 64'd0);
    checkOutput("reset done", 64'(bus16.done), 64'd0);
    checkOutput("reset inv", 64'(bus16.inv), 64'd0);
    checkOutput("reset gcd", 64'(bus16.gcd), 64'd0);
    checkOutput("reset no_inv", 64'(bus16.no_inv), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].m, vecs[i].neg,
                  vecs[i].inv, vecs[i].gcd, vecs[i].noInv, 0);
    end

    // Wide operands with a >= m on the 32-bit instance.
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = 32'hFFFFFFFF; bus32.m = 32'hFFFFFFFB; bus32.neg = 1'b0;
    @(negedge clk);
    bus32.start = 1'b0;
    lat = 1;
    while (!bus32.done && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    refModel(64'hFFFFFFFF, 64'hFFFFFFFB, 1'b0, mInv, mGcd, mNo, k);
    checkOutput("w32 timeout", 64'(!bus32.done), 64'd0);
    checkOutput("w32 inv", 64'(bus32.inv), 64'h3FFFFFFF);
    checkOutput("w32 gcd", 64'(bus32.gcd), 64'd1);
    checkOutput("w32 no_inv", 64'(bus32.no_inv), 64'd0);
    checkOutput("w32 latency", 64'(lat), 64'(3 + k * 34));

    // Start pulsed mid-operation with other operands must not disturb the first request.
    refModel(64'd1000, 64'd65519, 1'b0, mInv, mGcd, mNo, k);
    runAndCheck("busy_start", 16'd1000, 16'd65519, 1'b0, 16'(mInv), 16'(mGcd), mNo, 5);

    // Start arriving exactly in the done cycle is dropped.
    applyStimulus(16'd3, 16'd11, 1'b0, 0, lat, timedOut, busyEarly);
    checkOutput("donecyc timeout", 64'(timedOut), 64'd0);
    bus16.start = 1'b1; bus16.a = 16'd6; bus16.m = 16'd9; bus16.neg = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0;
    checkOutput("donecyc busy", 64'(bus16.busy), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus16.done) sawDone = 1'b1;
    end
    checkOutput("donecyc no_done", 64'(sawDone), 64'd0);
    checkOutput("donecyc inv_held", 64'(bus16.inv), 64'd4);

    // Abort mid-division: outputs clear and the abandoned request never completes.
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = 16'd1234; bus16.m = 16'd65521; bus16.neg = 1'b0;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(bus16.busy), 64'd0);
    checkOutput("abort done", 64'(bus16.done), 64'd0);
    checkOutput("abort inv", 64'(bus16.inv), 64'd0);
    checkOutput("abort gcd", 64'(bus16.gcd), 64'd0);
    checkOutput("abort no_inv", 64'(bus16.no_inv), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus16.done || bus16.busy) sawDone = 1'b1;
    end
    checkOutput("abort quiet", 64'(sawDone), 64'd0);
    refModel(64'd1234, 64'd65521, 1'b0, mInv, mGcd, mNo, k);
    runAndCheck("after_abort", 16'd1234, 16'd65521, 1'b0, 16'(mInv), 16'(mGcd), mNo, 0);

    // Random sweep against the reference model plus the defining inverse property.
    for (int i = 0; i < 30; i++) begin
      rm = (($urandom % 4) == 0) ? 16'($urandom_range(20, 0)) : 16'($urandom);
      ra = (($urandom % 8) == 0) ? 16'd0 : 16'($urandom);
      rn = 1'($urandom);
      refModel(longint'(ra), longint'(rm), rn, mInv, mGcd, mNo, k);
      runAndCheck($sformatf("rnd%0d", i), ra, rm, rn, 16'(mInv), 16'(mGcd), mNo, 0);
      if (!mNo) begin
        prod = (longint'(bus16.inv) * longint'(ra)) % longint'(rm);
        checkOutput($sformatf("rnd%0d property", i), 64'(prod),
                    rn ? 64'(longint'(rm) - 1) : 64'd1);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
